// File: rtl/stdp_pkg.sv
// Shared state encoding and arithmetic helpers for the STDP learning engine.
package stdp_pkg;

  localparam int N_DEFAULT = 7;
  localparam int PAIRS     = N_DEFAULT * N_DEFAULT;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } stdp_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Sum is formed at full integer width so the clamp sees the true value before truncation.
  function automatic int sat_add(input int w, input int d, input int lo, input int hi);
    int s;
    s = w + d;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/stdp_trace_bank.sv
// Per-neuron eligibility traces: reload on spike, decay on tick, snapshot on accept.
module stdp_trace_bank
  import stdp_pkg::*;
#(
  parameter int N         = 7,
  parameter int TRACE_W   = 4,
  parameter int TRACE_MAX = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 reload,
  input  logic [N-1:0]         reload_vec,
  input  logic                 decay_tick,
  output logic [N*TRACE_W-1:0] snapshot
);

  logic [TRACE_W-1:0] trace [N];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < N; n++) trace[n] <= '0;
      snapshot <= '0;
    end else begin
      for (int n = 0; n < N; n++) begin
        if (reload) snapshot[n*TRACE_W +: TRACE_W] <= trace[n];
        // A firing neuron reloads even when a decay tick lands on the same edge.
        if (reload && reload_vec[n])
          trace[n] <= TRACE_W'(TRACE_MAX);
        else if (decay_tick && trace[n] != '0)
          trace[n] <= trace[n] - TRACE_W'(1);
      end
    end
  end

endmodule

// File: rtl/stdp_learning_engine.sv
// Pair-based STDP engine sweeping one synapse per cycle; WEIGHT_LEAK_EN adds 1-LSB leak on idle pairs.
//   state | meaning
//   IDLE  | waiting for a spike event (ready when learning_enable)
//   SWEEP | updating pair k = i*N+j, one per cycle, N*N cycles
//   DONE  | one-cycle done pulse, then back to IDLE
module stdp_learning_engine
  import stdp_pkg::*;
#(
  parameter int           N         = N_DEFAULT,
  parameter int           W         = 16,
  parameter int           TRACE_W   = 4,
  parameter int           TRACE_MAX = 8,
  parameter int           ETA       = 4,
  parameter logic [N-1:0] INH_MASK  = 7'b1000000,
  parameter int           WMAX      = 2048,
  parameter int           WMIN      = -2048
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 learning_enable,
  input  logic                 spike_valid,
  input  logic [N-1:0]         spike_vec,
  output logic                 spike_ready,
  input  logic                 decay_tick,
  output logic                 busy,
  output logic                 done,
  input  logic [idx_w(N)-1:0]  rd_post,
  input  logic [idx_w(N)-1:0]  rd_pre,
  output logic [W-1:0]         rd_weight,
  output logic [N*N*W-1:0]     weights_flat
);

  localparam int NP    = N * N;
  localparam int KW    = idx_w(NP);
  localparam int IW    = idx_w(N);
  localparam int EXT_W = W + TRACE_W + 2;

  stdp_state_e state, state_next;
  logic [KW-1:0]          k;
  logic [IW-1:0]          pi, pj;
  logic [N-1:0]           s_vec;
  logic [N*TRACE_W-1:0]   snap;
  logic                   accept, wr_en;
  logic [TRACE_W-1:0]     t_i, t_j;
  logic signed [EXT_W-1:0] ltp, ltd, d_raw, d;
  logic signed [W-1:0]    w_cur, w_new;

  stdp_trace_bank #(
    .N         (N),
    .TRACE_W   (TRACE_W),
    .TRACE_MAX (TRACE_MAX)
  ) u_traces (
    .clk        (clk),
    .reset_n    (reset_n),
    .reload     (accept),
    .reload_vec (spike_vec),
    .decay_tick (decay_tick),
    .snapshot   (snap)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    spike_ready = 1'b0;
    accept      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        spike_ready = learning_enable;
        accept      = spike_valid && learning_enable;
        if (accept) state_next = SWEEP;
      end
      SWEEP: begin
        busy = 1'b1;
        if (k == KW'(NP - 1)) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pair datapath: traces come only from the accept-time snapshot.
  always_comb begin
    t_i   = snap[pi*TRACE_W +: TRACE_W];
    t_j   = snap[pj*TRACE_W +: TRACE_W];
    w_cur = weights_flat[k*W +: W];
    ltp   = s_vec[pi] ? EXT_W'(ETA) * EXT_W'(t_j) : '0;
    ltd   = s_vec[pj] ? EXT_W'(ETA) * EXT_W'(t_i) : '0;
    d_raw = ltp - ltd;
    d     = (INH_MASK[pi] | INH_MASK[pj]) ? -d_raw : d_raw;
`ifdef WEIGHT_LEAK_EN
    if (d == '0) begin
      if (w_cur == '0)  w_new = w_cur;
      else if (w_cur[W-1]) w_new = w_cur + W'(1);
      else              w_new = w_cur - W'(1);
    end else begin
      w_new = W'(sat_add(int'(w_cur), int'(d), WMIN, WMAX));
    end
`else
    w_new = W'(sat_add(int'(w_cur), int'(d), WMIN, WMAX));
`endif
    wr_en = (state == SWEEP) && (pi != pj);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k            <= '0;
      pi           <= '0;
      pj           <= '0;
      s_vec        <= '0;
      weights_flat <= '0;
    end else if (accept) begin
      s_vec <= spike_vec;
      k     <= '0;
      pi    <= '0;
      pj    <= '0;
    end else if (state == SWEEP) begin
      k <= k + KW'(1);
      if (pj == IW'(N - 1)) begin
        pj <= '0;
        pi <= pi + IW'(1);
      end else begin
        pj <= pj + IW'(1);
      end
      if (wr_en) weights_flat[k*W +: W] <= w_new;
    end
  end

  always_comb begin
    rd_weight = '0;
    if (int'(rd_post) < N && int'(rd_pre) < N)
      rd_weight = weights_flat[(int'(rd_post) * N + int'(rd_pre)) * W +: W];
  end

endmodule

// File: tb/tb_stdp_learning_engine.sv
// Self-checking bench for stdp_learning_engine: directed table, handshake sequences, random vs. model.
module tb_stdp_learning_engine;

  localparam int N = 7, W = 16, TMAX = 8, ETA = 4, WMAX = 2048, WMIN = -2048, NP = N * N;
  localparam logic [N-1:0] INH = 7'b1000000;
`ifdef WEIGHT_LEAK_EN
  localparam int LEAK = 1;
`else
  localparam int LEAK = 0;
`endif

  logic clk = 1'b0, reset_n = 1'b0, learning_enable = 1'b0, spike_valid = 1'b0, decay_tick = 1'b0;
  logic [N-1:0]     spike_vec = '0;
  logic             spike_ready, busy, done;
  logic [2:0]       rd_post = '0, rd_pre = '0;
  logic [W-1:0]     rd_weight;
  logic [N*N*W-1:0] weights_flat;

  int errors = 0, checks = 0;
  int mw [N][N];
  int mtr [N];
  int mcnt;

  always #5 clk = ~clk;

  stdp_learning_engine dut (
    .clk(clk), .reset_n(reset_n), .learning_enable(learning_enable),
    .spike_valid(spike_valid), .spike_vec(spike_vec), .spike_ready(spike_ready),
    .decay_tick(decay_tick), .busy(busy), .done(done),
    .rd_post(rd_post), .rd_pre(rd_pre), .rd_weight(rd_weight), .weights_flat(weights_flat)
  );

  typedef struct {
    bit           rst;
    bit           ev;
    int           ticks;
    bit           tick_acc;
    logic [N-1:0] vec;
    int           post;
    int           pre;
    int           expw;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dutw(input int i, input int j);
    return int'($signed(weights_flat[(i*N+j)*W +: W]));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mtr[i] = 0;
      for (int j = 0; j < N; j++) mw[i][j] = 0;
    end
    mcnt = 0;
  endtask

  // Reference: whole sweep applied at accept using pre-event traces.
  task automatic model_edge();
    int t [N];
    int ltp, ltd, dd, v;
    bit acc;
    acc = spike_valid && learning_enable && (mcnt == 0);
    if (acc) begin
      t = mtr;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (i != j) begin
            ltp = spike_vec[i] ? ETA * t[j] : 0;
            ltd = spike_vec[j] ? ETA * t[i] : 0;
            dd  = ltp - ltd;
            if (INH[i] || INH[j]) dd = -dd;
            if (dd == 0) begin
              if (LEAK != 0 && mw[i][j] > 0) mw[i][j] = mw[i][j] - 1;
              else if (LEAK != 0 && mw[i][j] < 0) mw[i][j] = mw[i][j] + 1;
            end else begin
              v = mw[i][j] + dd;
              mw[i][j] = (v > WMAX) ? WMAX : (v < WMIN) ? WMIN : v;
            end
          end
      mcnt = NP + 1;
    end else if (mcnt > 0) begin
      mcnt--;
    end
    for (int n = 0; n < N; n++) begin
      if (acc && spike_vec[n]) mtr[n] = TMAX;
      else if (decay_tick && mtr[n] > 0) mtr[n] = mtr[n] - 1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_weights(input string name);
    int bad, bi, bj;
    bad = 0; bi = 0; bj = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (dutw(i, j) != mw[i][j]) begin
          if (bad == 0) begin bi = i; bj = j; end
          bad++;
        end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d weights differ, w[%0d][%0d] got %0d expected %0d",
               name, bad, bi, bj, dutw(bi, bj), mw[bi][bj]);
    end
  endtask

  task automatic rd_check(input string name, input int p, input int q, input int exp);
    rd_post = 3'(p);
    rd_pre  = 3'(q);
    #1;
    chk(name, int'($signed(rd_weight)), exp);
  endtask

  task automatic do_reset();
    spike_valid = 1'b0;
    decay_tick  = 1'b0;
    reset_n     = 1'b0;
    model_reset();
    #2 reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    decay_tick = 1'b1;
    repeat (n) cyc();
    decay_tick = 1'b0;
  endtask

  task automatic send(input logic [N-1:0] v, input bit tick_acc);
    int n;
    spike_vec   = v;
    spike_valid = 1'b1;
    decay_tick  = tick_acc;
    n = 0;
    while (!spike_ready && n < 200) begin cyc(); n++; end
    chk("accept_ready", int'(spike_ready), 1);
    cyc();
    spike_valid = 1'b0;
    decay_tick  = 1'b0;
    n = 1;
    while (!done && n < 60) begin cyc(); n++; end
    chk("done_latency", n, NP + 1);
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad;
    tbl[0]  = '{1'b1, 1'b1, 0, 1'b0, 7'b0000001, 1, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 3, 1'b0, 7'b0000010, 1, 0, 20};
    tbl[2]  = '{1'b0, 1'b0, 0, 1'b0, 7'b0000000, 0, 1, -20};
    tbl[3]  = '{1'b0, 1'b0, 0, 1'b0, 7'b0000000, 1, 1, 0};
    tbl[4]  = '{1'b1, 1'b1, 0, 1'b0, 7'b1000000, 0, 6, 0};
    tbl[5]  = '{1'b0, 1'b1, 0, 1'b0, 7'b0000001, 0, 6, -32};
    tbl[6]  = '{1'b0, 1'b0, 0, 1'b0, 7'b0000000, 6, 0, 32};
    tbl[7]  = '{1'b1, 1'b1, 0, 1'b1, 7'b0000100, 2, 5, 0};
    tbl[8]  = '{1'b0, 1'b1, 0, 1'b0, 7'b0100000, 5, 2, 32};
    tbl[9]  = '{1'b0, 1'b0, 0, 1'b0, 7'b0000000, 2, 5, -32};
    tbl[10] = '{1'b1, 1'b1, 0, 1'b0, 7'b0000001, 3, 4, 0};
    tbl[11] = '{1'b0, 1'b1, 3, 1'b0, 7'b0000010, 1, 0, 20};
    tbl[12] = '{1'b0, 1'b1, 8, 1'b0, 7'b0011000, 1, 0, 20 - LEAK};
    tbl[13] = '{1'b0, 1'b0, 0, 1'b0, 7'b0000000, 0, 1, -20 + LEAK};

    // Reset state
    model_reset();
    learning_enable = 1'b1;
    repeat (2) @(negedge clk);
    check_weights("reset_weights");
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", int'(spike_ready), 1);

    foreach (tbl[e]) begin
      if (tbl[e].rst) do_reset();
      if (tbl[e].ev) begin
        ticks(tbl[e].ticks);
        send(tbl[e].vec, tbl[e].tick_acc);
        check_weights($sformatf("tbl%0d_model", e));
      end
      rd_check($sformatf("tbl%0d_w%0d%0d", e, tbl[e].post, tbl[e].pre),
               tbl[e].post, tbl[e].pre, tbl[e].expw);
    end

    // Handshake: learning_enable gating, held request during sweep, enable drop mid-sweep
    do_reset();
    learning_enable = 1'b0;
    spike_vec = 7'b0000001;
    spike_valid = 1'b1;
    #1 chk("ready_le0", int'(spike_ready), 0);
    cyc(); cyc();
    chk("no_accept_le0", int'(busy), 0);
    learning_enable = 1'b1;
    #1 chk("ready_le1", int'(spike_ready), 1);
    cyc();
    spike_vec = 7'b0000010;
    n = 0; bad = 0;
    while (n < 60 && !done) begin
      if (spike_ready) bad++;
      if (n == 9) learning_enable = 1'b0;
      if (n == 48) learning_enable = 1'b1;
      cyc();
      n++;
    end
    chk("held_not_accepted", bad, 0);
    chk("done_le_drop", n + 1, NP + 1);
    chk("ready_in_done", int'(spike_ready), 0);
    cyc();
    chk("ready_after_done", int'(spike_ready), 1);
    chk("idle_after_done", int'(busy), 0);
    cyc();
    chk("held_accepted", int'(busy), 1);
    spike_valid = 1'b0;
    n = 0;
    while (!done && n < 60) begin cyc(); n++; end
    chk("held_done_seen", int'(done), 1);
    cyc();
    check_weights("handshake_weights");
    rd_check("hs_w10", 1, 0, 32);

    // Reset mid-sweep
    spike_vec = 7'b0000001;
    spike_valid = 1'b1;
    cyc();
    spike_valid = 1'b0;
    repeat (10) cyc();
    chk("midsweep_busy", int'(busy), 1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_weights("midsweep_reset_weights");
    chk("midsweep_reset_busy", int'(busy), 0);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("midsweep_ready", int'(spike_ready), 1);

    // Saturation
    do_reset();
    for (int it = 0; it < 70; it++) begin
      send(7'b0000001, 1'b0);
      send(7'b0000010, 1'b0);
      ticks(8);
    end
    rd_check("sat_w10", 1, 0, WMAX);
    rd_check("sat_w01", 0, 1, WMIN);
    check_weights("sat_model");

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      spike_valid     = ($urandom_range(0, 3) == 0);
      spike_vec       = N'($urandom);
      decay_tick      = ($urandom_range(0, 4) == 0);
      learning_enable = ($urandom_range(0, 9) != 0);
      #1;
      chk("rand_ctrl", int'({spike_ready, busy, done}),
          int'({(mcnt == 0) && learning_enable, mcnt != 0, mcnt == 1}));
      if (mcnt == 0) check_weights("rand_weights");
      cyc();
    end
    spike_valid = 1'b0;
    decay_tick  = 1'b0;
    n = 0;
    while (mcnt != 0 && n < 100) begin cyc(); n++; end
    check_weights("rand_final");
    for (int r = 0; r < 8; r++) begin
      int p, q;
      p = $urandom_range(0, N - 1);
      q = $urandom_range(0, N - 1);
      rd_check("rand_rd", p, q, mw[p][q]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
